// File: rtl/ib_lut_pkg.sv
// Shared types and helpers for the double-buffered IB LUT memory.
package ib_lut_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_VN0 = 3'd1,
        LD_VN1 = 3'd2,
        LD_DN  = 3'd3,
        FULL   = 3'd4
    } ld_state_t;

    // Which table the loader is currently writing.
    localparam logic [1:0] TBL_NONE = 2'd0;
    localparam logic [1:0] TBL_VN0  = 2'd1;
    localparam logic [1:0] TBL_VN1  = 2'd2;
    localparam logic [1:0] TBL_DN   = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // An iteration counter needs at least one bit even for a single iteration.
    function automatic int iter_bw(input int iter_num);
        return (iter_num > 1) ? clog2(iter_num) : 1;
    endfunction

    function automatic logic [1:0] table_sel(input ld_state_t st);
        logic [1:0] sel;
        case (st)
            LD_VN0:  sel = TBL_VN0;
            LD_VN1:  sel = TBL_VN1;
            LD_DN:   sel = TBL_DN;
            default: sel = TBL_NONE;
        endcase
        return sel;
    endfunction

    function automatic ld_state_t next_phase(input ld_state_t st);
        ld_state_t nxt;
        case (st)
            LD_VN0:  nxt = LD_VN1;
            LD_VN1:  nxt = LD_DN;
            default: nxt = FULL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ib_lut_pingpong_bank.sv
// One double-buffered LUT: two read ports on the active page, one write
// port on the shadow page, so reads and writes never touch the same page.
module ib_lut_pingpong_bank #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2048,
    parameter int ADDR_BW = 11,
    parameter int RD_PIPE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active_page,
    input  logic               we,
    input  logic [ADDR_BW-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [ADDR_BW-1:0] addr_a,
    input  logic [ADDR_BW-1:0] addr_b,
    output logic [WIDTH-1:0]   dout_a,
    output logic [WIDTH-1:0]   dout_b
);

    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    always_ff @(posedge clk) begin
        if (we) begin
            if (active_page) mem0[waddr] <= wdata;
            else             mem1[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            rd_a <= active_page ? mem1[addr_a] : mem0[addr_a];
            rd_b <= active_page ? mem1[addr_b] : mem0[addr_b];
        end
    end

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic [WIDTH-1:0] pipe_a;
            logic [WIDTH-1:0] pipe_b;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_a <= '0;
                    pipe_b <= '0;
                end else begin
                    pipe_a <= rd_a;
                    pipe_b <= rd_b;
                end
            end
            assign dout_a = pipe_a;
            assign dout_b = pipe_b;
        end else begin : g_nopipe
            assign dout_a = rd_a;
            assign dout_b = rd_b;
        end
    endgenerate

endmodule

// File: rtl/ib_lut_pingpong_mem.sv
// Double-buffered IB LUT memory: the decoder reads the active page while the
// stream loader fills the shadow page; a swap handshake flips the pages.
module ib_lut_pingpong_mem
    import ib_lut_pkg::*;
#(
    parameter int VN_RD_BW   = 8,
    parameter int DN_RD_BW   = 2,
    parameter int VN_ADDR_BW = 11,
    parameter int DN_ADDR_BW = 11,
    parameter int VN_DEPTH   = 2048,
    parameter int DN_DEPTH   = 2048,
    parameter int ITER_NUM   = 10,
    parameter int RD_PIPE    = 1
) (
    input  logic                         write_clk,
    input  logic                         rst,
    input  logic [VN_ADDR_BW-1:0]        vn_m0_portA_addr,
    input  logic [VN_ADDR_BW-1:0]        vn_m0_portB_addr,
    input  logic [VN_ADDR_BW-1:0]        vn_m1_portA_addr,
    input  logic [VN_ADDR_BW-1:0]        vn_m1_portB_addr,
    input  logic [DN_ADDR_BW-1:0]        dn_portA_addr,
    input  logic [DN_ADDR_BW-1:0]        dn_portB_addr,
    output logic [VN_RD_BW-1:0]          vn_m0_portA_dout,
    output logic [VN_RD_BW-1:0]          vn_m0_portB_dout,
    output logic [VN_RD_BW-1:0]          vn_m1_portA_dout,
    output logic [VN_RD_BW-1:0]          vn_m1_portB_dout,
    output logic [DN_RD_BW-1:0]          dn_portA_dout,
    output logic [DN_RD_BW-1:0]          dn_portB_dout,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [VN_RD_BW-1:0]          load_data,
    output logic                         load_ready,
    output logic                         shadow_full,
    input  logic                         page_swap_req,
    output logic                         page_swap_ack,
    output logic                         active_page,
    output logic [iter_bw(ITER_NUM)-1:0] active_iter,
    output logic [2:0]                   dbg_state
);

    localparam int CNT_BW  = ((VN_ADDR_BW > DN_ADDR_BW) ? VN_ADDR_BW : DN_ADDR_BW) + 1;
    localparam int ITER_BW = iter_bw(ITER_NUM);
    localparam logic [CNT_BW-1:0]  VN_LAST   = CNT_BW'(VN_DEPTH - 1);
    localparam logic [CNT_BW-1:0]  DN_LAST   = CNT_BW'(DN_DEPTH - 1);
    localparam logic [ITER_BW-1:0] ITER_LAST = ITER_BW'(ITER_NUM - 1);

    ld_state_t         state, state_nxt;
    logic [CNT_BW-1:0] cnt, cnt_nxt, last_idx;
    logic              xfer, swap_fire;
    logic [1:0]        tbl;

    // Load handshake: a word moves on any edge where load_valid & load_ready;
    // load_ready depends only on state, never on load_valid.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_ready = 1'b0;
        swap_fire  = 1'b0;
        last_idx   = (state == LD_DN) ? DN_LAST : VN_LAST;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LD_VN0;
                    cnt_nxt   = '0;
                end
            end
            LD_VN0, LD_VN1, LD_DN: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (cnt == last_idx) begin
                        state_nxt = next_phase(state);
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_BW'(1);
                    end
                end
            end
            FULL: begin
                // Swap has priority; a simultaneous load_start is dropped.
                if (page_swap_req) begin
                    swap_fire = 1'b1;
                    state_nxt = IDLE;
                end else if (load_start) begin
                    state_nxt = LD_VN0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            page_swap_ack <= 1'b0;
            active_page   <= 1'b0;
            active_iter   <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            page_swap_ack <= swap_fire;
            if (swap_fire) begin
                active_page <= ~active_page;
                active_iter <= (active_iter == ITER_LAST) ? '0 : active_iter + ITER_BW'(1);
            end
        end
    end

    assign xfer        = load_valid & load_ready;
    assign tbl         = table_sel(state);
    assign shadow_full = (state == FULL);
    assign dbg_state   = state;

    ib_lut_pingpong_bank #(
        .WIDTH(VN_RD_BW), .DEPTH(VN_DEPTH), .ADDR_BW(VN_ADDR_BW), .RD_PIPE(RD_PIPE)
    ) u_vn_m0 (
        .clk(write_clk), .rst(rst), .active_page(active_page),
        .we(xfer && (tbl == TBL_VN0)), .waddr(cnt[VN_ADDR_BW-1:0]), .wdata(load_data),
        .addr_a(vn_m0_portA_addr), .addr_b(vn_m0_portB_addr),
        .dout_a(vn_m0_portA_dout), .dout_b(vn_m0_portB_dout)
    );

    ib_lut_pingpong_bank #(
        .WIDTH(VN_RD_BW), .DEPTH(VN_DEPTH), .ADDR_BW(VN_ADDR_BW), .RD_PIPE(RD_PIPE)
    ) u_vn_m1 (
        .clk(write_clk), .rst(rst), .active_page(active_page),
        .we(xfer && (tbl == TBL_VN1)), .waddr(cnt[VN_ADDR_BW-1:0]), .wdata(load_data),
        .addr_a(vn_m1_portA_addr), .addr_b(vn_m1_portB_addr),
        .dout_a(vn_m1_portA_dout), .dout_b(vn_m1_portB_dout)
    );

    ib_lut_pingpong_bank #(
        .WIDTH(DN_RD_BW), .DEPTH(DN_DEPTH), .ADDR_BW(DN_ADDR_BW), .RD_PIPE(RD_PIPE)
    ) u_dn (
        .clk(write_clk), .rst(rst), .active_page(active_page),
        .we(xfer && (tbl == TBL_DN)), .waddr(cnt[DN_ADDR_BW-1:0]),
        .wdata(load_data[DN_RD_BW-1:0]),
        .addr_a(dn_portA_addr), .addr_b(dn_portB_addr),
        .dout_a(dn_portA_dout), .dout_b(dn_portB_dout)
    );

endmodule

// File: tb/tb_ib_lut_pingpong_mem.sv
// Bench for ib_lut_pingpong_mem: small tables, random loader gaps and random
// concurrent reads checked against a page-level model of the LUT contents.
module tb_ib_lut_pingpong_mem;
  import ib_lut_pkg::*;

  localparam int VN_RD_BW = 8;
  localparam int DN_RD_BW = 2;
  localparam int VN_ADDR_BW = 2;
  localparam int DN_ADDR_BW = 2;
  localparam int VN_DEPTH = 4;
  localparam int DN_DEPTH = 4;
  localparam int ITER_NUM = 3;
  localparam int RD_PIPE = 1;
  localparam int N_WORDS = 2 * VN_DEPTH + DN_DEPTH;

  logic clk, rst;
  logic [1:0] vn_m0_portA_addr, vn_m0_portB_addr, vn_m1_portA_addr, vn_m1_portB_addr;
  logic [1:0] dn_portA_addr, dn_portB_addr;
  logic [7:0] vn_m0_portA_dout, vn_m0_portB_dout, vn_m1_portA_dout, vn_m1_portB_dout;
  logic [1:0] dn_portA_dout, dn_portB_dout;
  logic load_start, load_valid, load_ready, shadow_full;
  logic [7:0] load_data;
  logic page_swap_req, page_swap_ack, active_page;
  logic [1:0] active_iter;
  logic [2:0] dbg_state;

  ib_lut_pingpong_mem #(
    .VN_RD_BW(VN_RD_BW), .DN_RD_BW(DN_RD_BW), .VN_ADDR_BW(VN_ADDR_BW),
    .DN_ADDR_BW(DN_ADDR_BW), .VN_DEPTH(VN_DEPTH), .DN_DEPTH(DN_DEPTH),
    .ITER_NUM(ITER_NUM), .RD_PIPE(RD_PIPE)
  ) dut (
    .write_clk(clk), .rst(rst),
    .vn_m0_portA_addr(vn_m0_portA_addr), .vn_m0_portB_addr(vn_m0_portB_addr),
    .vn_m1_portA_addr(vn_m1_portA_addr), .vn_m1_portB_addr(vn_m1_portB_addr),
    .dn_portA_addr(dn_portA_addr), .dn_portB_addr(dn_portB_addr),
    .vn_m0_portA_dout(vn_m0_portA_dout), .vn_m0_portB_dout(vn_m0_portB_dout),
    .vn_m1_portA_dout(vn_m1_portA_dout), .vn_m1_portB_dout(vn_m1_portB_dout),
    .dn_portA_dout(dn_portA_dout), .dn_portB_dout(dn_portB_dout),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .shadow_full(shadow_full),
    .page_swap_req(page_swap_req), .page_swap_ack(page_swap_ack),
    .active_page(active_page), .active_iter(active_iter), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] m_vn0 [2][4];
  logic [7:0] m_vn1 [2][4];
  logic [1:0] m_dn [2][4];
  bit page_loaded [2];
  logic m_page = 1'b0;
  int m_iter = 0;
  logic [7:0] ld_words [N_WORDS];
  bit reads_on = 1'b0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [67:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called just after a falling edge; data is due 1 + RD_PIPE rising edges later.
  task automatic issue_read(input logic [1:0] a0, b0, a1, b1, da, db);
    logic [31:0] due;
    due = 32'(cyc + 1 + RD_PIPE);
    vn_m0_portA_addr = a0; vn_m0_portB_addr = b0;
    vn_m1_portA_addr = a1; vn_m1_portB_addr = b1;
    dn_portA_addr = da; dn_portB_addr = db;
    exp_q.push_back({due, m_vn0[m_page][a0], m_vn0[m_page][b0], m_vn1[m_page][a1],
                     m_vn1[m_page][b1], m_dn[m_page][da], m_dn[m_page][db]});
  endtask

  // monitor
  initial begin
    logic [67:0] e;
    logic [35:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && int'(exp_q[0][67:36]) <= cyc) begin
        e = exp_q.pop_front();
        act = {vn_m0_portA_dout, vn_m0_portB_dout, vn_m1_portA_dout, vn_m1_portB_dout,
               dn_portA_dout, dn_portB_dout};
        checks++;
        if (int'(e[67:36]) != cyc || act !== e[35:0]) begin
          failures++;
          $display("FAIL rd_data actual=%09h required=%09h due=%0d cycle=%0d",
                   act, e[35:0], e[67:36], cyc);
        end
      end
    end
  end

  // background random reader on the active page
  initial begin
    forever begin
      @(negedge clk);
      if (reads_on && page_loaded[m_page])
        issue_read(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  end

  // ---------------- driver tasks (start and end just after a falling edge) ----------------
  task automatic run_load(input int stop_after, input bit poke_swap, input bit gaps);
    int k;
    int budget;
    logic sh;
    k = 0;
    budget = 0;
    sh = ~m_page;
    page_loaded[sh] = 1'b0;
    load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    while (k < stop_after && budget < 300) begin
      check("load_ready_loading", load_ready, 1);
      check("shadow_full_loading", shadow_full, 0);
      check("ack_while_loading", page_swap_ack, 0);
      check("page_while_loading", active_page, m_page);
      page_swap_req = poke_swap && k >= VN_DEPTH && k < 2 * VN_DEPTH;
      load_start = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data = load_valid ? ld_words[k] : 8'($urandom_range(0, 255));
      @(posedge clk);
      if (load_valid) begin
        if (k < VN_DEPTH) m_vn0[sh][k] = ld_words[k];
        else if (k < 2 * VN_DEPTH) m_vn1[sh][k - VN_DEPTH] = ld_words[k];
        else m_dn[sh][k - 2 * VN_DEPTH] = ld_words[k][1:0];
        k++;
      end
      budget++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    page_swap_req = 1'b0;
    if (budget >= 300) check("load_budget", 32'(k), 32'(stop_after));
    if (stop_after == N_WORDS) begin
      check("shadow_full_after_last", shadow_full, 1);
      check("load_ready_after_last", load_ready, 0);
      page_loaded[sh] = 1'b1;
    end
  endtask

  task automatic do_swap(input bit with_start);
    check("ack_before_swap", page_swap_ack, 0);
    check("full_before_swap", shadow_full, 1);
    page_swap_req = 1'b1;
    load_start = with_start;
    @(posedge clk);
    m_page = ~m_page;
    m_iter = (m_iter + 1) % ITER_NUM;
    @(negedge clk);
    page_swap_req = 1'b0;
    load_start = 1'b0;
    check("ack_pulse", page_swap_ack, 1);
    check("active_page_swap", active_page, m_page);
    check("active_iter_swap", active_iter, m_iter);
    check("shadow_full_after_swap", shadow_full, 0);
    @(negedge clk);
    check("ack_one_cycle", page_swap_ack, 0);
    check("idle_after_swap", load_ready, 0);
    check("state_after_swap", dbg_state, IDLE);
  endtask

  task automatic drain();
    repeat (RD_PIPE + 3) @(negedge clk);
    check("read_queue_drained", exp_q.size(), 0);
  endtask

  task automatic sweep_reads();
    for (int i = 0; i < 4; i++) begin
      issue_read(2'(i), 2'(3 - i), 2'(i), 2'(3 - i), 2'(i), 2'(3 - i));
      @(negedge clk);
    end
    drain();
  endtask

  task automatic random_words();
    for (int i = 0; i < N_WORDS; i++) ld_words[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic reset_checks();
    check("rst_vn_m0_a", vn_m0_portA_dout, 0);
    check("rst_vn_m0_b", vn_m0_portB_dout, 0);
    check("rst_vn_m1_a", vn_m1_portA_dout, 0);
    check("rst_vn_m1_b", vn_m1_portB_dout, 0);
    check("rst_dn_a", dn_portA_dout, 0);
    check("rst_dn_b", dn_portB_dout, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_shadow_full", shadow_full, 0);
    check("rst_ack", page_swap_ack, 0);
    check("rst_active_page", active_page, 0);
    check("rst_active_iter", active_iter, 0);
    check("rst_state", dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; page_swap_req = 1'b0;
    vn_m0_portA_addr = '0; vn_m0_portB_addr = '0; vn_m1_portA_addr = '0;
    vn_m1_portB_addr = '0; dn_portA_addr = '0; dn_portB_addr = '0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_load_ready", load_ready, 0);
    check("idle_shadow_full", shadow_full, 0);
    check("idle_swap_ignored_ack", page_swap_ack, 0);

    // directed full load with fixed contents
    for (int i = 0; i < 4; i++) begin
      ld_words[i] = 8'(8'h10 + i);
      ld_words[i + 4] = 8'(8'h20 + i);
      ld_words[i + 8] = 8'((i + 1) % 4);
    end
    run_load(N_WORDS, 1'b0, 1'b0);
    do_swap(1'b0);
    issue_read(2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3);
    repeat (1 + RD_PIPE) @(negedge clk);
    check("vn_m1_b_addr2", vn_m1_portB_dout, 8'h22);
    check("dn_a_addr2", dn_portA_dout, 2'd3);
    sweep_reads();

    // gapped load with an illegal swap during LD_VN1, reads running meanwhile
    random_words();
    reads_on = 1'b1;
    run_load(N_WORDS, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("full_holds", shadow_full, 1);
    do_swap(1'b1);
    repeat (6) @(negedge clk);
    reads_on = 1'b0;
    drain();

    // reset in the middle of a load, then a clean reload
    random_words();
    run_load(5, 1'b0, 1'b0);
    rst = 1'b1;
    m_page = 1'b0;
    m_iter = 0;
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    random_words();
    reads_on = 1'b1;
    run_load(N_WORDS, 1'b0, 1'b1);
    do_swap(1'b0);
    reads_on = 1'b0;
    drain();
    sweep_reads();

    // iteration wrap across several load/swap rounds with concurrent reads
    reads_on = 1'b1;
    for (int r = 0; r < 3; r++) begin
      random_words();
      run_load(N_WORDS, r == 1, 1'b1);
      do_swap(r == 2);
      repeat (4) @(negedge clk);
    end
    reads_on = 1'b0;
    drain();
    sweep_reads();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
